// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer and its downstream
// sequence-detector test environment.
package word_serializer_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/word_serializer.sv
// Parallel-in, serial-out bit streamer with a valid/ready load port.
// Back-to-back words stream with no idle cycle between them.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             word_done
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state, state_next;
    logic [WIDTH-1:0] sr, sr_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             accept;
    logic             last_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    sr_next    = data_in;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    // Move the next bit toward whichever end drives out.
                    sr_next  = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
                    cnt_next = cnt + CW'(1);
                end else if (accept) begin
                    sr_next  = data_in;
                    cnt_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last_bit   = (cnt == LAST);
        load_ready = (state == IDLE) || last_bit;
        accept     = load_valid && load_ready;
        out_valid  = (state == SHIFT);
        word_done  = (state == SHIFT) && last_bit;
        out        = 1'b0;
        if (state == SHIFT) begin
            out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: MSB-first and LSB-first instances share one stimulus,
// checked by a vector table, hand sequences and a bit-queue reference model.
module tb_word_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lv  = 1'b0;
    logic [W-1:0] din = '0;

    logic ready_m, out_m, valid_m, done_m;
    logic ready_l, out_l, valid_l, done_l;

    int checks = 0;
    int errors = 0;

    bit qm[$];
    bit ql[$];

    typedef struct {
        logic         rst;
        logic         lv;
        logic [W-1:0] din;
        logic         e_m;
        logic         e_l;
        int           st;   // 0: idle, 1: mid-word, 2: last bit
    } vec_t;

    vec_t vecs[$];

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(rst), .data_in(din), .load_valid(lv),
        .load_ready(ready_m), .out(out_m), .out_valid(valid_m), .word_done(done_m)
    );

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(rst), .data_in(din), .load_valid(lv),
        .load_ready(ready_l), .out(out_l), .out_valid(valid_l), .word_done(done_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out_m"}, out_m, 1'b0);
        chk({tag, " out_l"}, out_l, 1'b0);
        chk({tag, " valid_m"}, valid_m, 1'b0);
        chk({tag, " valid_l"}, valid_l, 1'b0);
        chk({tag, " done_m"}, done_m, 1'b0);
        chk({tag, " ready_m"}, ready_m, 1'b1);
        chk({tag, " ready_l"}, ready_l, 1'b1);
    endtask

    function automatic vec_t mk(logic r, logic v, logic [W-1:0] d, logic m, logic l, int st);
        vec_t x;
        x.rst = r; x.lv = v; x.din = d; x.e_m = m; x.e_l = l; x.st = st;
        return x;
    endfunction

    // Reference model: each accepted word appends its bits, in stream order, to a queue;
    // one bit leaves the queue per clock.
    task automatic step();
        logic [W-1:0] w;
        bit           acc;
        chk("rnd out_m", out_m, qm.size() > 0 ? qm[0] : 1'b0);
        chk("rnd out_l", out_l, ql.size() > 0 ? ql[0] : 1'b0);
        chk("rnd valid_m", valid_m, qm.size() > 0);
        chk("rnd valid_l", valid_l, ql.size() > 0);
        chk("rnd done_m", done_m, qm.size() == 1);
        chk("rnd done_l", done_l, ql.size() == 1);
        chk("rnd ready_m", ready_m, qm.size() <= 1);
        chk("rnd ready_l", ready_l, ql.size() <= 1);
        rst = ($urandom_range(0, 63) == 0);
        lv  = ($urandom_range(0, 9) < 7);
        din = W'($urandom);
        w   = din;
        acc = !rst && lv && (qm.size() <= 1);
        @(posedge clk);
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc) begin
                for (int unsigned k = 0; k < W; k++) begin
                    qm.push_back(w[W-1-k]);
                    ql.push_back(w[k]);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // single word 0xAA
        vecs.push_back(mk(0, 1, 8'hAA, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0));
        // back-to-back 0xA5 then 0x3C with load_valid held
        vecs.push_back(mk(0, 1, 8'hA5, 1, 1, 1));
        vecs.push_back(mk(0, 1, 8'h3C, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h3C, 1, 1, 1));
        vecs.push_back(mk(0, 1, 8'h3C, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h3C, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h3C, 1, 1, 1));
        vecs.push_back(mk(0, 1, 8'h3C, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h3C, 1, 1, 2));
        vecs.push_back(mk(0, 1, 8'h3C, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0));
        // 0xF0, with 0x0F offered from bit 2 onward
        vecs.push_back(mk(0, 1, 8'hF0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h0F, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h0F, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h0F, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h0F, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h0F, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h0F, 0, 1, 2));
        vecs.push_back(mk(0, 1, 8'h0F, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 2));
        // reset together with a load: nothing captured
        vecs.push_back(mk(1, 1, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0));
        // 0x07
        vecs.push_back(mk(0, 1, 8'h07, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0));

        // reset state
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post-reset");

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            lv  = vecs[i].lv;
            din = vecs[i].din;
            @(negedge clk);
            chk($sformatf("vec%0d out_m", i), out_m, vecs[i].e_m);
            chk($sformatf("vec%0d out_l", i), out_l, vecs[i].e_l);
            chk($sformatf("vec%0d valid", i), valid_m, vecs[i].st != 0);
            chk($sformatf("vec%0d valid_l", i), valid_l, vecs[i].st != 0);
            chk($sformatf("vec%0d done", i), done_m, vecs[i].st == 2);
            chk($sformatf("vec%0d done_l", i), done_l, vecs[i].st == 2);
            chk($sformatf("vec%0d ready", i), ready_m, vecs[i].st != 1);
        end
        rst = 1'b0;
        lv  = 1'b0;

        // asynchronous reset between edges during bit 3 of 0xFF
        lv  = 1'b1;
        din = 8'hFF;
        @(negedge clk);
        lv  = 1'b0;
        din = 8'h00;
        repeat (3) @(negedge clk);
        chk("midword out_m", out_m, 1'b1);
        chk("midword valid", valid_m, 1'b1);
        #1 rst = 1'b1;
        #1 chk_idle("async reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk_idle("after reset");
        end

        repeat (600) step();
        rst = 1'b0;
        lv  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
